param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/param_counter.sv | 108 ++++++++++
 tb/tb_param_counter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/param_counter.sv
`default_nettype none
// ============================================================================
//  Module      : param_counter
//  Description : Up/down counter bounded to 0..MAX_VAL with wrap or saturate
//                boundary handling, synchronous load and clear, a registered
//                one-cycle boundary pulse and a sticky boundary flag.
//  Ports       : clock        - rising-edge clock
//                reset        - asynchronous active-low reset
//                io_en        - step enable (one step per cycle)
//                io_up        - 1 = count up, 0 = count down
//                io_sat       - 0 = wrap at boundary, 1 = saturate
//                io_load      - synchronous load strobe
//                io_load_val  - value to load (clamped to MAX_VAL)
//                io_clear     - synchronous clear of count and sticky flag
//                io_out       - current count (direct register output)
//                io_tc        - pulse for the cycle after a boundary event
//                io_ovf       - sticky: boundary event since clear/reset
//  Revision    : 1.0 - initial release
// ============================================================================
module param_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_up,
    input  logic             io_sat,
    input  logic             io_load,
    input  logic [WIDTH-1:0] io_load_val,
    input  logic             io_clear,
    output logic [WIDTH-1:0] io_out,
    output logic             io_tc,
    output logic             io_ovf
);

    localparam logic [WIDTH-1:0] c_max     = WIDTH'(MAX_VAL);
    localparam logic [WIDTH:0]   c_max_ext = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_load_ext;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_next_count;
    logic             w_event;
    logic             w_next_ovf;

    // Increment is formed one bit wider so that count+1 can never alias
    // back into range; "at max" is then simply "the increment overshoots".
    assign w_sum      = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign w_load_ext = {1'b0, io_load_val};
    assign w_at_max   = (w_sum > c_max_ext);
    assign w_at_zero  = (r_count == '0);

    always_comb begin
        w_next_count = r_count;
        w_event      = 1'b0;
        w_next_ovf   = r_ovf;
        if (io_clear) begin
            w_next_count = '0;
            w_next_ovf   = 1'b0;
        end else if (io_load) begin
            w_next_count = (w_load_ext > c_max_ext) ? c_max : io_load_val;
        end else if (io_en) begin
            if (io_up) begin
                if (w_at_max) begin
                    w_event      = 1'b1;
                    w_next_count = io_sat ? c_max : '0;
                end else begin
                    w_next_count = w_sum[WIDTH-1:0];
                end
            end else begin
                if (w_at_zero) begin
                    w_event      = 1'b1;
                    w_next_count = io_sat ? '0 : c_max;
                end else begin
                    w_next_count = r_count - c_one;
                end
            end
            if (w_event) begin
                w_next_ovf = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next_count;
            r_tc    <= w_event;
            r_ovf   <= w_next_ovf;
        end
    end

    assign io_out = r_count;
    assign io_tc  = r_tc;
    assign io_ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_param_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_counter
//  Description : Self-checking bench for param_counter. Two instances
//                (8-bit/MAX 10 and 4-bit/MAX 15) share control inputs and are
//                compared every cycle against an arithmetic reference model,
//                with directed sequences pinning literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0, clear = 1'b0;
    logic [7:0] load_val = 8'd0;

    logic [7:0] out_a;
    logic       tc_a, ovf_a;
    logic [3:0] out_b;
    logic       tc_b, ovf_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    always #5 clock = ~clock;

    param_counter #(.WIDTH(8), .MAX_VAL(10)) u_dut_a (
        .clock(clock), .reset(reset), .io_en(en), .io_up(up), .io_sat(sat),
        .io_load(load), .io_load_val(load_val), .io_clear(clear),
        .io_out(out_a), .io_tc(tc_a), .io_ovf(ovf_a)
    );

    param_counter #(.WIDTH(4), .MAX_VAL(15)) u_dut_b (
        .clock(clock), .reset(reset), .io_en(en), .io_up(up), .io_sat(sat),
        .io_load(load), .io_load_val(load_val[3:0]), .io_clear(clear),
        .io_out(out_b), .io_tc(tc_b), .io_ovf(ovf_b)
    );

    // ---------------- reference model ----------------
    function automatic int nxt(int c, int mx, int lv, bit e, bit u, bit s,
                               bit ld, bit cl);
        if (cl) return 0;
        if (ld) return (lv > mx) ? mx : lv;
        if (!e) return c;
        if (u)  return (c == mx) ? (s ? mx : 0) : c + 1;
        return (c == 0) ? (s ? 0 : mx) : c - 1;
    endfunction

    function automatic bit evt(int c, int mx, bit e, bit u, bit ld, bit cl);
        return e && !ld && !cl && (u ? (c == mx) : (c == 0));
    endfunction

    logic [7:0] ma = 8'd0;
    logic       ta = 1'b0, oa = 1'b0;
    logic [3:0] mb = 4'd0;
    logic       tbm = 1'b0, ob = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ma <= 8'd0; ta <= 1'b0; oa <= 1'b0;
            mb <= 4'd0; tbm <= 1'b0; ob <= 1'b0;
        end else begin
            ma  <= 8'(nxt(int'(ma), 10, int'(load_val), en, up, sat, load, clear));
            ta  <= evt(int'(ma), 10, en, up, load, clear);
            oa  <= clear ? 1'b0 : (evt(int'(ma), 10, en, up, load, clear) ? 1'b1 : oa);
            mb  <= 4'(nxt(int'(mb), 15, int'(load_val[3:0]), en, up, sat, load, clear));
            tbm <= evt(int'(mb), 15, en, up, load, clear);
            ob  <= clear ? 1'b0 : (evt(int'(mb), 15, en, up, load, clear) ? 1'b1 : ob);
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("model_out_a", 32'(out_a), 32'(ma));
            chk("model_tc_a",  32'(tc_a),  32'(ta));
            chk("model_ovf_a", 32'(ovf_a), 32'(oa));
            chk("model_out_b", 32'(out_b), 32'(mb));
            chk("model_tc_b",  32'(tc_b),  32'(tbm));
            chk("model_ovf_b", 32'(ovf_b), 32'(ob));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        cmp_on = 1'b1;
        chk("reset_out", 32'(out_a), 32'd0);
        chk("reset_tc",  32'(tc_a),  32'd0);
        chk("reset_ovf", 32'(ovf_a), 32'd0);
        reset = 1'b1;

        // Up-count with wrap from reset: 1..10 then 0 with pulse.
        en = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("wrap_up_out", 32'(out_a), (i <= 10) ? i : i - 11);
            chk("wrap_up_tc",  32'(tc_a),  (i == 11) ? 1 : 0);
            chk("wrap_up_ovf", 32'(ovf_a), (i >= 11) ? 1 : 0);
        end

        // Saturated hold at MAX with enable high: repeated pulses.
        load = 1'b1; load_val = 8'd10; tick();
        chk("load10_tc", 32'(tc_a), 32'd0);
        load = 1'b0; sat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_hold_out", 32'(out_a), 32'd10);
            chk("sat_hold_tc",  32'(tc_a),  32'd1);
        end

        // Clamped load then down-count with wrap.
        load = 1'b1; load_val = 8'd200; en = 1'b0; tick();
        chk("clamp_load_out", 32'(out_a), 32'd10);
        chk("clamp_load_b",   32'(out_b), 32'd8);
        load = 1'b0; up = 1'b0; sat = 1'b0; en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk("wrap_dn_out", 32'(out_a), (i <= 10) ? 10 - i : 10);
            chk("wrap_dn_tc",  32'(tc_a),  (i == 11) ? 1 : 0);
        end

        // Clear wins over load and enable.
        en = 1'b0; load = 1'b1; load_val = 8'd7; tick();
        chk("pre_clear_out", 32'(out_a), 32'd7);
        chk("pre_clear_ovf", 32'(ovf_a), 32'd1);
        clear = 1'b1; en = 1'b1; load_val = 8'd3; tick();
        chk("clear_out", 32'(out_a), 32'd0);
        chk("clear_ovf", 32'(ovf_a), 32'd0);
        chk("clear_tc",  32'(tc_a),  32'd0);
        clear = 1'b0; load = 1'b0; en = 1'b0;

        // Asynchronous reset mid-cycle.
        load = 1'b1; load_val = 8'd5; tick();
        chk("pre_reset_out", 32'(out_a), 32'd5);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_out", 32'(out_a), 32'd0);
        chk("async_reset_ovf", 32'(ovf_a), 32'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        tick();
        chk("post_reset_out", 32'(out_a), 32'd1);

        // 4-bit full-range wrap on the second instance.
        en = 1'b0; clear = 1'b1; tick();
        clear = 1'b0; load = 1'b1; load_val = 8'd14; tick();
        chk("b_load14", 32'(out_b), 32'd14);
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0; tick();
        chk("b_15_out", 32'(out_b), 32'd15);
        chk("b_15_tc",  32'(tc_b),  32'd0);
        tick();
        chk("b_wrap_out", 32'(out_b), 32'd0);
        chk("b_wrap_tc",  32'(tc_b),  32'd1);
        chk("b_wrap_ovf", 32'(ovf_b), 32'd1);

        // Randomized phase, checked by the model every cycle.
        for (int i = 0; i < 2000; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            up    = $urandom_range(0, 1) != 0;
            sat   = $urandom_range(0, 1) != 0;
            load  = ($urandom_range(0, 15) == 0);
            clear = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 3))
                0:       load_val = 8'($urandom_range(0, 255));
                1:       load_val = 8'($urandom_range(8, 12));
                2:       load_val = 8'($urandom_range(13, 17));
                default: load_val = 8'($urandom_range(0, 3));
            endcase
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                #1;
                chk("rand_async_reset", 32'(out_a), 32'd0);
                @(negedge clock);
                #2 reset = 1'b1;
            end
            tick();
        end

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
